// File: rtl/ex_issue_stage.sv
// Issue stage in front of the 64-bit ALU: resolves RAW hazards by bypassing
// MEM/WB results, selects ALU operands and registers the bundle for execute.
// A load sitting in the output register stalls any dependent instruction for
// one cycle so its data can be picked up from the WB/MEM bypass.
module ex_issue_stage #(
  parameter int XLEN    = 64,
  parameter int ALUOP_W = 6,
  parameter int RIDX_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [RIDX_W-1:0]  in_rs1,
  input  logic [RIDX_W-1:0]  in_rs2,
  input  logic               in_uses_rs1,
  input  logic               in_uses_rs2,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_src1_is_pc,
  input  logic               in_src2_is_imm,
  input  logic [ALUOP_W-1:0] in_alu_op,
  input  logic [RIDX_W-1:0]  in_rd,
  input  logic               in_rd_we,
  input  logic               in_is_load,

  input  logic               fwd_mem_valid,
  input  logic [RIDX_W-1:0]  fwd_mem_rd,
  input  logic [XLEN-1:0]    fwd_mem_data,
  input  logic               fwd_wb_valid,
  input  logic [RIDX_W-1:0]  fwd_wb_rd,
  input  logic [XLEN-1:0]    fwd_wb_data,

  input  logic               flush,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_operator_1,
  output logic [XLEN-1:0]    out_operator_2,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic [XLEN-1:0]    out_pc,
  output logic [RIDX_W-1:0]  out_rd,
  output logic               out_rd_we,
  output logic               out_is_load
);

  logic [XLEN-1:0] rs1Fwd;
  logic [XLEN-1:0] rs2Fwd;
  logic            rs1HitsLoad;
  logic            rs2HitsLoad;
  logic            loadUse;
  logic            capture;

  // rs1 bypass: x0 is hardwired zero, MEM is newer than WB so it wins
  always_comb begin
    rs1Fwd = in_rs1_data;
    if (in_rs1 == '0)
      rs1Fwd = '0;
    else if (fwd_mem_valid && (fwd_mem_rd == in_rs1))
      rs1Fwd = fwd_mem_data;
    else if (fwd_wb_valid && (fwd_wb_rd == in_rs1))
      rs1Fwd = fwd_wb_data;
  end

  // rs2 bypass, same priority as rs1
  always_comb begin
    rs2Fwd = in_rs2_data;
    if (in_rs2 == '0)
      rs2Fwd = '0;
    else if (fwd_mem_valid && (fwd_mem_rd == in_rs2))
      rs2Fwd = fwd_mem_data;
    else if (fwd_wb_valid && (fwd_wb_rd == in_rs2))
      rs2Fwd = fwd_wb_data;
  end

  // out_rd is already zeroed for non-writing bundles, so rd==0 covers that case too
  assign rs1HitsLoad = in_uses_rs1 && (in_rs1 == out_rd);
  assign rs2HitsLoad = in_uses_rs2 && (in_rs2 == out_rd);
  assign loadUse     = out_valid && out_is_load && out_rd_we && (out_rd != '0) &&
                       (rs1HitsLoad || rs2HitsLoad);

  assign in_ready = !flush && !loadUse && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  // Output bundle register: flush kills, capture loads, consume drains, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_operator_1 <= '0;
      out_operator_2 <= '0;
      out_rs2_data   <= '0;
      out_alu_op     <= '0;
      out_pc         <= '0;
      out_rd         <= '0;
      out_rd_we      <= 1'b0;
      out_is_load    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid      <= 1'b1;
      out_operator_1 <= in_src1_is_pc  ? in_pc  : rs1Fwd;
      out_operator_2 <= in_src2_is_imm ? in_imm : rs2Fwd;
      out_rs2_data   <= rs2Fwd;
      out_alu_op     <= in_alu_op;
      out_pc         <= in_pc;
      out_rd         <= in_rd_we ? in_rd : '0;
      out_rd_we      <= in_rd_we;
      out_is_load    <= in_is_load;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
